// File: rtl/input_cache_pkg.sv
// Shared types and width helpers for the ping-pong activation cache.
package input_cache_pkg;

    typedef enum logic [1:0] {
        EMPTY,
        FULL,
        DRAINING
    } bank_state_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD
    } rd_state_t;

    // Index width that never collapses to zero bits.
    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/input_pingpong_cache_if.sv
// Host write port and array read port of the ping-pong activation cache.
interface input_pingpong_cache_if #(
    parameter int DATA_W = 32,
    parameter int ROWS   = 64,
    parameter int LANES  = 16
);
    logic                       wr_valid;
    logic                       wr_ready;
    logic [$clog2(ROWS)-1:0]    wr_row;
    logic [$clog2(LANES)-1:0]   wr_lane;
    logic [DATA_W-1:0]          wr_data;
    logic                       wr_commit;
    logic                       rd_start;
    logic [$clog2(ROWS):0]      rd_num_rows;
    logic                       rd_valid;
    logic                       rd_ready;
    logic [LANES*DATA_W-1:0]    rd_data;
    logic                       rd_last;
    logic [1:0]                 bank_full;
    logic                       fill_sel;

    modport master (
        output wr_valid, wr_row, wr_lane, wr_data, wr_commit,
        output rd_start, rd_num_rows, rd_ready,
        input  wr_ready, rd_valid, rd_data, rd_last, bank_full, fill_sel
    );

    modport slave (
        input  wr_valid, wr_row, wr_lane, wr_data, wr_commit,
        input  rd_start, rd_num_rows, rd_ready,
        output wr_ready, rd_valid, rd_data, rd_last, bank_full, fill_sel
    );
endinterface

// File: rtl/cache_bank.sv
// One cache bank: word-granular write port, registered full-row read port.
// INPUT_CACHE_ZERO_FILL_EN adds a written-mask so unwritten lanes read as zero.
module cache_bank
    import input_cache_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ROWS   = 64,
    parameter int LANES  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en_i,
    input  logic [$clog2(ROWS)-1:0]   wr_row_i,
    input  logic [$clog2(LANES)-1:0]  wr_lane_i,
    input  logic [DATA_W-1:0]         wr_data_i,
    input  logic                      rd_en_i,
    input  logic [$clog2(ROWS)-1:0]   rd_row_i,
`ifdef INPUT_CACHE_ZERO_FILL_EN
    input  logic                      mask_clr_i,
`endif
    output logic [LANES*DATA_W-1:0]   rd_data_o
);
    logic [DATA_W-1:0]       mem_q [ROWS][LANES];
    logic [LANES*DATA_W-1:0] rdData_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_row_i][wr_lane_i] <= wr_data_i;
        end
    end

`ifdef INPUT_CACHE_ZERO_FILL_EN
    logic [LANES-1:0] written_q [ROWS];

    // Mask clear wins over a write; the top never writes a bank while clearing it.
    always_ff @(posedge clk) begin
        if (rst || mask_clr_i) begin
            written_q <= '{default: '0};
        end else if (wr_en_i) begin
            written_q[wr_row_i][wr_lane_i] <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rdData_q <= '0;
        end else if (rd_en_i) begin
            for (int k = 0; k < LANES; k++) begin
`ifdef INPUT_CACHE_ZERO_FILL_EN
                rdData_q[k*DATA_W +: DATA_W] <= written_q[rd_row_i][k] ? mem_q[rd_row_i][k] : '0;
`else
                rdData_q[k*DATA_W +: DATA_W] <= mem_q[rd_row_i][k];
`endif
            end
        end
    end

    assign rd_data_o = rdData_q;
endmodule

// File: rtl/input_pingpong_cache.sv
// Double-buffered activation cache: host fills one bank while the array drains the other.
// INPUT_CACHE_ZERO_FILL_EN makes unwritten lanes read back as zero.
module input_pingpong_cache
    import input_cache_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ROWS   = 64,
    parameter int LANES  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input_pingpong_cache_if.slave cache
);
    localparam int RW = idx_w(ROWS);
    localparam int NW = RW + 1;

    bank_state_t             bankState_q [2];
    bank_state_t             bankState_d [2];
    rd_state_t               rdState_q, rdState_d;
    logic                    fillSel_q, fillSel_d;
    logic                    drainSel_q, drainSel_d;
    logic [RW-1:0]           rowCnt_q, rowCnt_d;
    logic [NW-1:0]           numRows_q, numRows_d;
    logic                    rdValid_q, rdValid_d;
    logic                    rdLast_q, rdLast_d;
    logic                    wrReady;
    logic                    bankRdEn;
    logic [RW-1:0]           bankRdRow;
    logic [LANES*DATA_W-1:0] bankRdData [2];

    always_ff @(posedge clk) begin
        if (rst) begin
            bankState_q[0] <= EMPTY;
            bankState_q[1] <= EMPTY;
            rdState_q      <= IDLE;
            fillSel_q      <= 1'b0;
            drainSel_q     <= 1'b0;
            rowCnt_q       <= '0;
            numRows_q      <= '0;
            rdValid_q      <= 1'b0;
            rdLast_q       <= 1'b0;
        end else begin
            bankState_q    <= bankState_d;
            rdState_q      <= rdState_d;
            fillSel_q      <= fillSel_d;
            drainSel_q     <= drainSel_d;
            rowCnt_q       <= rowCnt_d;
            numRows_q      <= numRows_d;
            rdValid_q      <= rdValid_d;
            rdLast_q       <= rdLast_d;
        end
    end

    // Commit and drain touch different banks (EMPTY vs DRAINING), so both may land together.
    always_comb begin
        wrReady     = (bankState_q[fillSel_q] == EMPTY);
        bankState_d = bankState_q;
        rdState_d   = rdState_q;
        fillSel_d   = fillSel_q;
        drainSel_d  = drainSel_q;
        rowCnt_d    = rowCnt_q;
        numRows_d   = numRows_q;
        rdValid_d   = rdValid_q;
        rdLast_d    = rdLast_q;
        bankRdEn    = 1'b0;
        bankRdRow   = rowCnt_q;

        if (cache.wr_commit && wrReady) begin
            bankState_d[fillSel_q] = FULL;
            fillSel_d              = !fillSel_q;
        end

        case (rdState_q)
            IDLE: begin
                if (cache.rd_start && (bankState_q[drainSel_q] == FULL) && (cache.rd_num_rows != '0)) begin
                    bankState_d[drainSel_q] = DRAINING;
                    rowCnt_d  = '0;
                    numRows_d = (cache.rd_num_rows > NW'(ROWS)) ? NW'(ROWS) : cache.rd_num_rows;
                    rdState_d = FETCH;
                end
            end
            FETCH: begin
                bankRdEn  = 1'b1;
                rdValid_d = 1'b1;
                rdLast_d  = (({1'b0, rowCnt_q} + NW'(1)) == numRows_q);
                rdState_d = HOLD;
            end
            HOLD: begin
                if (cache.rd_ready) begin
                    if (rdLast_q) begin
                        rdValid_d               = 1'b0;
                        rdLast_d                = 1'b0;
                        bankState_d[drainSel_q] = EMPTY;
                        drainSel_d              = !drainSel_q;
                        rdState_d               = IDLE;
                    end else begin
                        // Prefetch the next row so a ready consumer sees one row per cycle.
                        rowCnt_d  = rowCnt_q + RW'(1);
                        bankRdEn  = 1'b1;
                        bankRdRow = rowCnt_q + RW'(1);
                        rdLast_d  = (({1'b0, rowCnt_q} + NW'(2)) == numRows_q);
                    end
                end
            end
            default: rdState_d = IDLE;
        endcase
    end

`ifdef INPUT_CACHE_ZERO_FILL_EN
    logic drainDone;
    assign drainDone = (rdState_q == HOLD) && cache.rd_ready && rdLast_q;
`endif

    for (genvar b = 0; b < 2; b++) begin : gBank
        cache_bank #(
            .DATA_W (DATA_W),
            .ROWS   (ROWS),
            .LANES  (LANES)
        ) uBank (
            .clk        (clk),
            .rst        (rst),
            .wr_en_i    (cache.wr_valid && wrReady && (fillSel_q == 1'(b))),
            .wr_row_i   (cache.wr_row),
            .wr_lane_i  (cache.wr_lane),
            .wr_data_i  (cache.wr_data),
            .rd_en_i    (bankRdEn && (drainSel_q == 1'(b))),
            .rd_row_i   (bankRdRow),
`ifdef INPUT_CACHE_ZERO_FILL_EN
            .mask_clr_i (drainDone && (drainSel_q == 1'(b))),
`endif
            .rd_data_o  (bankRdData[b])
        );
    end

    assign cache.wr_ready  = wrReady;
    assign cache.rd_valid  = rdValid_q;
    assign cache.rd_last   = rdLast_q;
    assign cache.rd_data   = bankRdData[drainSel_q];
    assign cache.bank_full = {bankState_q[1] == FULL, bankState_q[0] == FULL};
    assign cache.fill_sel  = fillSel_q;
endmodule

// File: tb/tb_input_pingpong_cache.sv
// Scoreboard bench for input_pingpong_cache: directed scenarios then random traffic
// against a bank-level reference model.
module tb_input_pingpong_cache;
    localparam int DATA_W = 32;
    localparam int ROWS   = 4;
    localparam int LANES  = 4;
    localparam int RW     = $clog2(ROWS);
    localparam int LW     = $clog2(LANES);
    localparam int NW     = RW + 1;
    localparam int ROW_W  = LANES * DATA_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    input_pingpong_cache_if #(.DATA_W(DATA_W), .ROWS(ROWS), .LANES(LANES)) cacheIf ();

    input_pingpong_cache #(.DATA_W(DATA_W), .ROWS(ROWS), .LANES(LANES)) dut (
        .clk   (clk),
        .rst   (rst),
        .cache (cacheIf)
    );

    int checkCount = 0;
    int passCount  = 0;

    typedef struct {
        logic [ROW_W-1:0] data;
        logic [ROW_W-1:0] care;
        logic             last;
    } row_t;
    row_t expQ[$];

    // Reference model: bank contents, which words hold defined data, and bank occupancy.
    logic [DATA_W-1:0] mMem   [2][ROWS][LANES];
    bit                mKnown [2][ROWS][LANES];
    bit                mFull  [2];
    bit                mBusy  [2];
    int                mFill, mDrain, mDelay, mLeft;
    bit                mDraining;

    task automatic compareValue(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic modelReset();
        for (int b = 0; b < 2; b++) begin
            mFull[b] = 1'b0;
            mBusy[b] = 1'b0;
            for (int r = 0; r < ROWS; r++)
                for (int k = 0; k < LANES; k++) mKnown[b][r][k] = 1'b0;
        end
        mFill = 0; mDrain = 0; mDelay = 0; mLeft = 0; mDraining = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs about to be sampled.
    task automatic modelStep(input bit wv, input int row, input int lane, input logic [DATA_W-1:0] data,
                             input bit commit, input bit start, input int nrows, input bit ready, input bit r);
        bit canWrite, startOk, finish;
        int n;
        if (r) begin
            modelReset();
            expQ.delete();
            return;
        end
        canWrite = !mFull[mFill] && !mBusy[mFill];
        startOk  = !mDraining && start && mFull[mDrain] && (nrows != 0);
        finish   = 1'b0;
        if (mDraining) begin
            if (mDelay > 0) mDelay--;
            else if (ready) begin
                mLeft--;
                finish = (mLeft == 0);
            end
        end
        if (wv && canWrite) begin
            mMem[mFill][row][lane]   = data;
            mKnown[mFill][row][lane] = 1'b1;
        end
        if (commit && canWrite) begin
            mFull[mFill] = 1'b1;
            mFill ^= 1;
        end
        if (startOk) begin
            n = (nrows > ROWS) ? ROWS : nrows;
            mFull[mDrain] = 1'b0;
            mBusy[mDrain] = 1'b1;
            mDraining = 1'b1;
            mDelay = 1;
            mLeft = n;
            for (int rr = 0; rr < n; rr++) begin
                row_t e;
                e.data = '0;
                e.care = '0;
                e.last = (rr == n - 1);
                for (int k = 0; k < LANES; k++) begin
`ifdef INPUT_CACHE_ZERO_FILL_EN
                    e.care[k*DATA_W +: DATA_W] = '1;
                    if (mKnown[mDrain][rr][k]) e.data[k*DATA_W +: DATA_W] = mMem[mDrain][rr][k];
`else
                    if (mKnown[mDrain][rr][k]) begin
                        e.care[k*DATA_W +: DATA_W] = '1;
                        e.data[k*DATA_W +: DATA_W] = mMem[mDrain][rr][k];
                    end
`endif
                end
                expQ.push_back(e);
            end
        end
        if (finish) begin
            mBusy[mDrain] = 1'b0;
            mDraining = 1'b0;
`ifdef INPUT_CACHE_ZERO_FILL_EN
            for (int rr = 0; rr < ROWS; rr++)
                for (int k = 0; k < LANES; k++) mKnown[mDrain][rr][k] = 1'b0;
`endif
            mDrain ^= 1;
        end
    endtask

    task automatic checkOutput();
        bit expValid;
        expValid = mDraining && (mDelay == 0);
        compareValue("rd_valid", ROW_W'(cacheIf.rd_valid), ROW_W'(expValid));
        compareValue("wr_ready", ROW_W'(cacheIf.wr_ready), ROW_W'(!mFull[mFill] && !mBusy[mFill]));
        compareValue("bank_full", ROW_W'(cacheIf.bank_full), ROW_W'({mFull[1], mFull[0]}));
        compareValue("fill_sel", ROW_W'(cacheIf.fill_sel), ROW_W'(mFill));
        if (!expValid) compareValue("rd_last_idle", ROW_W'(cacheIf.rd_last), ROW_W'(0));
    endtask

    task automatic applyStimulus(input bit wv, input int row, input int lane, input logic [DATA_W-1:0] data,
                                 input bit commit, input bit start, input int nrows, input bit ready, input bit r);
        @(negedge clk);
        checkOutput();
        #1;
        cacheIf.wr_valid    = wv;
        cacheIf.wr_row      = RW'(row);
        cacheIf.wr_lane     = LW'(lane);
        cacheIf.wr_data     = data;
        cacheIf.wr_commit   = commit;
        cacheIf.rd_start    = start;
        cacheIf.rd_num_rows = NW'(nrows);
        cacheIf.rd_ready    = ready;
        rst                 = r;
        modelStep(wv, row, lane, data, commit, start, nrows, ready, r);
    endtask

    task automatic idleCycles(input int n, input bit ready);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, '0, 0, 0, 0, ready, 0);
    endtask

    task automatic fillBank(input int base);
        for (int r = 0; r < ROWS; r++)
            for (int k = 0; k < LANES; k++)
                applyStimulus(1, r, k, DATA_W'(base + r*16 + k), (r == ROWS-1) && (k == LANES-1), 0, 0, 0, 0);
    endtask

    // Monitor: pops one expected row per accepted handshake, compares every presented row.
    initial begin
        row_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst === 1'b0 && cacheIf.rd_valid === 1'b1) begin
                if (expQ.size() == 0) begin
                    checkCount++;
                    $display("[TB] FAIL unexpected_row: got rd_valid=1 with data 0x%0h, expected no row", cacheIf.rd_data);
                end else begin
                    e = expQ[0];
                    compareValue("rd_data", cacheIf.rd_data & e.care, e.data & e.care);
                    compareValue("rd_last", ROW_W'(cacheIf.rd_last), ROW_W'(e.last));
                    if (cacheIf.rd_ready) void'(expQ.pop_front());
                end
            end
        end
    end

    initial begin
        int readyPat [4] = '{1, 0, 0, 1};
        rst = 1'b1;
        cacheIf.wr_valid = 0; cacheIf.wr_row = '0; cacheIf.wr_lane = '0; cacheIf.wr_data = '0;
        cacheIf.wr_commit = 0; cacheIf.rd_start = 0; cacheIf.rd_num_rows = '0; cacheIf.rd_ready = 0;
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        compareValue("reset_rd_data", cacheIf.rd_data, '0);
        compareValue("reset_rd_last", ROW_W'(cacheIf.rd_last), ROW_W'(0));
        applyStimulus(0, 0, 0, '0, 0, 0, 0, 0, 0);

        $display("[TB] fill bank0, drain 4 rows with ready held high");
        fillBank(0);
        applyStimulus(0, 0, 0, '0, 0, 1, 4, 1, 0);
        idleCycles(6, 1);

        $display("[TB] commit both banks, dropped writes, then drain both");
        applyStimulus(0, 0, 0, '0, 0, 0, 0, 0, 1);
        fillBank(0);
        fillBank(8'h40);
        for (int i = 0; i < 3; i++) applyStimulus(1, i, i, 32'hBAD0_0000 + i, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, '0, 0, 1, 4, 1, 0);
        idleCycles(6, 1);
        applyStimulus(0, 0, 0, '0, 0, 1, 7, 1, 0);
        for (int i = 0; i < 12; i++) applyStimulus(0, 0, 0, '0, 0, 0, 0, readyPat[i % 4], 0);

        $display("[TB] ignored starts: banks empty, then zero row count");
        applyStimulus(0, 0, 0, '0, 0, 1, 4, 1, 0);
        idleCycles(3, 1);
        fillBank(8'h80);
        applyStimulus(0, 0, 0, '0, 0, 1, 0, 1, 0);
        idleCycles(3, 1);
        applyStimulus(0, 0, 0, '0, 0, 1, 2, 0, 0);
        idleCycles(3, 0);
        idleCycles(4, 1);

        $display("[TB] reset while holding row 2");
        fillBank(8'hC0);
        applyStimulus(0, 0, 0, '0, 0, 1, 4, 1, 0);
        idleCycles(3, 1);
        applyStimulus(0, 0, 0, '0, 0, 0, 0, 0, 1);
        idleCycles(2, 1);

        $display("[TB] single lane written, one row drained");
        applyStimulus(1, 0, 1, 32'hDEADBEEF, 1, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, '0, 0, 1, 1, 1, 0);
        idleCycles(4, 1);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 1), $urandom_range(0, ROWS-1), $urandom_range(0, LANES-1), $urandom,
                          ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0), $urandom_range(0, ROWS+2),
                          ($urandom_range(0, 2) != 0), ($urandom_range(0, 149) == 0));
        end
        idleCycles(20, 1);
        @(negedge clk);
        checkOutput();
        compareValue("rows_outstanding", ROW_W'(expQ.size()), ROW_W'(0));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule

// File: doc/input_pingpong_cache.md
Name: input_pingpong_cache

Overview:
- Double-buffered (ping-pong) activation cache in front of the systolic array.
- Host side writes one DATA_W word per handshake into the fill bank, then commits it.
- Array side streams whole LANES-wide rows out of the other bank under valid/ready.
- Generalises the single-bank write-word/read-row cache: filling and draining overlap, and back-pressure is supported.

Parameters:
- DATA_W, 32, bits per lane word
- ROWS, 64, rows per bank (power of two, ≥2)
- LANES, 16, words per row (power of two, ≥2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- wr_valid  in  1  write word valid
- wr_ready  out  1  fill bank accepts writes
- wr_row  in  $clog2(ROWS)  target row
- wr_lane  in  $clog2(LANES)  target lane
- wr_data  in  DATA_W  write word
- wr_commit  in  1  pulse: fill bank complete
- rd_start  in  1  pulse: begin draining
- rd_num_rows  in  $clog2(ROWS)+1  rows to stream from row 0
- rd_valid  out  1  rd_data valid
- rd_ready  in  1  consumer accepts row
- rd_data  out  LANES*DATA_W  row; lane k at bits [k*DATA_W +: DATA_W]
- rd_last  out  1  final row of drain
- bank_full  out  2  per-bank FULL status
- fill_sel  out  1  bank currently filling

Behaviour:
- Bank state: EMPTY, FULL, DRAINING, one state per bank.
- Pointers: fill_sel and drain_sel.
- Reset:
  - both banks EMPTY; fill_sel=0, drain_sel=0.
  - rd_valid=0, rd_last=0, rd_data=0, wr_ready=1, bank_full=2'b00.
  - Storage array is not reset.
- Writes:
  - wr_ready = (bank[fill_sel]==EMPTY).
  - A word is written when wr_valid & wr_ready; any row/lane order; overwrites are allowed.
- Commit:
  - wr_commit & wr_ready sets bank[fill_sel]=FULL and toggles fill_sel.
  - wr_commit while wr_ready=0 is ignored.
  - A write and a commit in the same cycle: the word is stored, then the bank commits.
- Read FSM states: IDLE, FETCH, HOLD.
- Read start:
  - In IDLE, rd_start with bank[drain_sel]==FULL and rd_num_rows≠0 → bank DRAINING, row counter=0, go to FETCH.
  - rd_start in any other condition is ignored.
  - rd_num_rows > ROWS is clipped to ROWS.
- FETCH:
  - Synchronous read of the row.
  - rd_data and rd_valid are registered next cycle; go to HOLD.
  - First-row latency is 2 cycles after rd_start.
- HOLD:
  - rd_data is stable while rd_valid & !rd_ready.
  - On accept of a non-last row: load the next row the same cycle (prefetch), so a continuously ready consumer gets 1 row/cycle.
  - rd_last=1 on the row with index n-1.
  - On accept of the last row: rd_valid=0, bank → EMPTY, drain_sel toggles, go to IDLE.
- Both banks FULL: wr_ready=0 until a drain completes.
- A drain completing and a commit in the same cycle are independent; both take effect.
- A mid-operation rst aborts everything to reset values; partially written data becomes don't-care.
- bank_full[i] = (bank[i]==FULL).

Optional Feature:
- Macro: INPUT_CACHE_ZERO_FILL_EN.
- Defined:
  - Each bank keeps a ROWS×LANES written-mask, cleared on reset and when that bank returns to EMPTY.
  - Unwritten lanes read as 0 in rd_data.
- Not defined:
  - No mask; unwritten lanes return stale storage contents (X after reset).

Decomposition:
- Package input_cache_pkg:
  - bank_state_t (EMPTY/FULL/DRAINING)
  - rd_state_t (IDLE/FETCH/HOLD)
  - width helper functions/localparams.
- Sub-module cache_bank:
  - one ROWS×LANES×DATA_W array with a word write port and a registered row read port
  - instantiated twice.

Test Plan:
- Fill bank0 (ROWS=4, LANES=4) with data = row*16+lane, commit, then rd_start with rd_num_rows=4 and rd_ready=1 → rows 0x00030201-pattern arrive on 4 consecutive cycles starting 2 cycles after start; rd_last on row 3; bank_full=00.
- Commit bank0 and bank1 without draining → wr_ready=0 and further writes dropped; after bank0 drains, wr_ready=1 and fill_sel=0.
- Toggle rd_ready 1,0,0,1 during drain → rd_data held stable while stalled; no row lost or duplicated.
- rd_start while both banks EMPTY, or with rd_num_rows=0 → ignored, rd_valid stays 0.
- Assert rst during HOLD on row 2 → next cycle rd_valid=0, wr_ready=1, bank_full=00, fill_sel=0.
- With INPUT_CACHE_ZERO_FILL_EN defined: write only lane 1 of row 0 = 0xDEADBEEF, commit, drain 1 row → rd_data lane1=0xDEADBEEF, all other lanes 0.
